// File: rtl/mc_mem_port_pkg.sv
// Shared definitions for the multicycle core memory port: size codes, port FSM states, NOP.
// The control FSM and the decoder use these as well.
package mc_mem_port_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } port_state_e;

    // Unsigned size codes exist only for loads.
    function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
        case (f3)
            F3_B, F3_H, F3_W: f3_legal = 1'b1;
            F3_BU, F3_HU:     f3_legal = !is_store;
            default:          f3_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_mem_port_if.sv
// Instruction/data bus between the memory port (master) and the memory system (slave).
interface mc_mem_port_if #(
    parameter int XLEN = 32
);
    logic            valid;
    logic            ready;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [3:0]      wstrb;
    logic [XLEN-1:0] rdata;
    logic            rvalid;

    modport master (output valid, we, addr, wdata, wstrb, input ready, rdata, rvalid);
    modport slave  (input valid, we, addr, wdata, wstrb, output ready, rdata, rvalid);
endinterface

// File: rtl/mc_lsu_align.sv
// Combinational byte-lane logic: store lane replication/strobes, request legality,
// and load extraction with sign/zero extension.
module mc_lsu_align
    import mc_mem_port_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      req_funct3,
    input  logic [1:0]      req_off,
    input  logic            req_store,
    input  logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] st_wdata,
    output logic [3:0]      st_wstrb,
    output logic            req_err,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_off,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] ld_data
);

    logic       misalign;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Low two funct3 bits carry the access size for both signed and unsigned codes.
    always_comb begin
        misalign = ((req_funct3[1:0] == 2'b01) && req_off[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_off != 2'b00));
        req_err  = !f3_legal(req_funct3, req_store) || misalign;
    end

    always_comb begin
        st_wdata = '0;
        st_wstrb = 4'b0000;
        case (req_funct3[1:0])
            2'b00: begin
                st_wdata = {4{store_data[7:0]}};
                st_wstrb = 4'b0001 << req_off;
            end
            2'b01: begin
                st_wdata = {2{store_data[15:0]}};
                st_wstrb = 4'b0011 << req_off;
            end
            2'b10: begin
                st_wdata = store_data;
                st_wstrb = 4'b1111;
            end
            default: begin
                st_wdata = '0;
                st_wstrb = 4'b0000;
            end
        endcase
    end

    always_comb begin
        ld_byte = rdata[8*ld_off +: 8];
        ld_half = rdata[16*ld_off[1] +: 16];
        ld_data = rdata;
        case (ld_funct3)
            F3_B:    ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            F3_H:    ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            F3_BU:   ld_data = {{(XLEN-8){1'b0}}, ld_byte};
            F3_HU:   ld_data = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/mc_mem_port.sv
// Unified instruction/data memory port for the multicycle core: request latch, valid/ready
// bus handshake with timeout, and the IR / load-data registers.
module mc_mem_port
    import mc_mem_port_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            core_req,
    input  logic            instruction_or_data,
    input  logic            mem_write,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] store_data,
    output logic            core_done,
    output logic            core_stall,
    output logic            core_err,
    output logic [31:0]     ir,
    output logic [XLEN-1:0] load_data,
    mc_mem_port_if.master   bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    port_state_e     state_q, state_d;
    logic [CNT_W-1:0] tmo_q, tmo_d, tmo_next;
    logic            fetch_q, fetch_d;
    logic            store_q, store_d;
    logic [2:0]      f3_q, f3_d;
    logic [1:0]      off_q, off_d;
    logic            bus_valid_q, bus_valid_d;
    logic            bus_we_q, bus_we_d;
    logic [XLEN-1:0] bus_addr_q, bus_addr_d;
    logic [XLEN-1:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]      bus_wstrb_q, bus_wstrb_d;
    logic            core_done_q, core_done_d;
    logic            core_err_q, core_err_d;
    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] load_data_q, load_data_d;

    logic [XLEN-1:0] eff_addr;
    logic [2:0]      eff_f3;
    logic            eff_store;
    logic [XLEN-1:0] st_wdata;
    logic [3:0]      st_wstrb;
    logic            req_err;
    logic [XLEN-1:0] ld_data;
    logic            accept;
    logic            tmo_hit;

    // Fetches are always word-sized reads from pc.
    assign eff_addr  = instruction_or_data ? alu_result : pc;
    assign eff_f3    = instruction_or_data ? funct3 : F3_W;
    assign eff_store = instruction_or_data & mem_write;

    mc_lsu_align #(.XLEN(XLEN)) u_align (
        .req_funct3 (eff_f3),
        .req_off    (eff_addr[1:0]),
        .req_store  (eff_store),
        .store_data (store_data),
        .st_wdata   (st_wdata),
        .st_wstrb   (st_wstrb),
        .req_err    (req_err),
        .ld_funct3  (f3_q),
        .ld_off     (off_q),
        .rdata      (bus.rdata),
        .ld_data    (ld_data)
    );

    assign accept   = bus_valid_q & bus.ready;
    assign tmo_next = tmo_q + 1'b1;
    assign tmo_hit  = (tmo_next == CNT_W'(TIMEOUT));

    always_comb begin
        state_d     = state_q;
        tmo_d       = '0;
        fetch_d     = fetch_q;
        store_d     = store_q;
        f3_d        = f3_q;
        off_d       = off_q;
        bus_valid_d = 1'b0;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wstrb_d = bus_wstrb_q;
        core_err_d  = 1'b0;
        ir_d        = ir_q;
        load_data_d = load_data_q;

        case (state_q)
            IDLE: begin
                if (core_req) begin
                    fetch_d = !instruction_or_data;
                    store_d = eff_store;
                    f3_d    = eff_f3;
                    off_d   = eff_addr[1:0];
                    if (req_err) begin
                        state_d    = DONE;
                        core_err_d = 1'b1;
                    end else begin
                        state_d     = REQ;
                        bus_addr_d  = {eff_addr[XLEN-1:2], 2'b00};
                        bus_we_d    = eff_store;
                        bus_wdata_d = eff_store ? st_wdata : '0;
                        bus_wstrb_d = eff_store ? st_wstrb : 4'b0000;
                    end
                end
            end
            // First REQ cycle sets up the bus fields; valid rises on the next one.
            REQ: begin
                tmo_d = tmo_next;
                if (accept) begin
                    state_d = store_q ? DONE : RESP;
                end else if (tmo_hit) begin
                    state_d    = DONE;
                    core_err_d = 1'b1;
                end else begin
                    bus_valid_d = 1'b1;
                end
            end
            RESP: begin
                tmo_d = tmo_next;
                if (bus.rvalid) begin
                    state_d = DONE;
                    if (fetch_q) ir_d = bus.rdata[31:0];
                    else         load_data_d = ld_data;
                end else if (tmo_hit) begin
                    state_d    = DONE;
                    core_err_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        core_done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            tmo_q       <= '0;
            fetch_q     <= 1'b0;
            store_q     <= 1'b0;
            f3_q        <= F3_W;
            off_q       <= 2'b00;
            bus_valid_q <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wstrb_q <= 4'b0000;
            core_done_q <= 1'b0;
            core_err_q  <= 1'b0;
            ir_q        <= NOP_INSN;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            fetch_q     <= fetch_d;
            store_q     <= store_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            bus_valid_q <= bus_valid_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wstrb_q <= bus_wstrb_d;
            core_done_q <= core_done_d;
            core_err_q  <= core_err_d;
            ir_q        <= ir_d;
            load_data_q <= load_data_d;
        end
    end

    assign bus.valid  = bus_valid_q;
    assign bus.we     = bus_we_q;
    assign bus.addr   = bus_addr_q;
    assign bus.wdata  = bus_wdata_q;
    assign bus.wstrb  = bus_wstrb_q;
    assign core_done  = core_done_q;
    assign core_err   = core_err_q;
    assign core_stall = core_req & ~core_done_q;
    assign ir         = ir_q;
    assign load_data  = load_data_q;

endmodule

// File: tb/tb_mc_mem_port.sv
// Directed bench for mc_mem_port: a bus responder inside the access task, with expected
// completions queued when each request is driven and checked when core_done appears.
module tb_mc_mem_port;

    localparam int XLEN = 32;
    localparam int TMO  = 8;

    typedef struct {
        int          lat;
        logic        err;
        logic [31:0] ir;
        logic [31:0] ld;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            core_req;
    logic            instruction_or_data;
    logic            mem_write;
    logic [2:0]      funct3;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] store_data;
    logic            core_done;
    logic            core_stall;
    logic            core_err;
    logic [31:0]     ir;
    logic [XLEN-1:0] load_data;

    mc_mem_port_if #(.XLEN(XLEN)) bus ();

    mc_mem_port #(.XLEN(XLEN), .TIMEOUT(TMO)) dut (
        .clk                 (clk),
        .reset               (reset),
        .core_req            (core_req),
        .instruction_or_data (instruction_or_data),
        .mem_write           (mem_write),
        .funct3              (funct3),
        .pc                  (pc),
        .alu_result          (alu_result),
        .store_data          (store_data),
        .core_done           (core_done),
        .core_stall          (core_stall),
        .core_err            (core_err),
        .ir                  (ir),
        .load_data           (load_data),
        .bus                 (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_mis = 0;
    exp_t        sb_q[$];
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_wstrb;
    logic        cap_we;
    int          n_valid, n_accept, n_unstable;
    logic [31:0] cur_ir, cur_ld;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete access: drives the request, plays memory, checks the completion.
    task automatic access(input string tag, input logic dat, input logic we,
                          input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                          input logic [31:0] rd, input int rdy_wait, input bit send_rv,
                          input int exp_lat, input logic exp_err,
                          input logic [31:0] exp_ir, input logic [31:0] exp_ld);
        exp_t e;
        exp_t got;
        int   cyc;
        int   vcnt;
        bit   done_seen;
        bit   pv;
        bit   pr;
        e.lat = exp_lat; e.err = exp_err; e.ir = exp_ir; e.ld = exp_ld;
        sb_q.push_back(e);
        core_req = 1'b1; instruction_or_data = dat; mem_write = we; funct3 = f3;
        store_data = sd;
        if (dat) alu_result = a; else pc = a;
        bus.ready = (rdy_wait == 0); bus.rvalid = 1'b0; bus.rdata = '0;
        cyc = 0; vcnt = 0; done_seen = 0; pv = 0; pr = 0;
        n_accept = 0; n_unstable = 0;
        cap_addr = '0; cap_wdata = '0; cap_wstrb = '0; cap_we = 1'b0;
        while (!done_seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            chk({tag, ".stall"}, core_stall, core_req && !core_done);
            bus.rvalid = 1'b0;
            if (pv && pr) begin
                n_accept++;
                if (!(dat && we) && send_rv) begin
                    bus.rvalid = 1'b1;
                    bus.rdata  = rd;
                end
            end
            if (bus.valid) begin
                vcnt++;
                if (vcnt == 1) begin
                    cap_addr = bus.addr; cap_wdata = bus.wdata;
                    cap_wstrb = bus.wstrb; cap_we = bus.we;
                end else if (bus.addr !== cap_addr || bus.wdata !== cap_wdata ||
                             bus.wstrb !== cap_wstrb || bus.we !== cap_we) begin
                    n_unstable++;
                end
            end
            if (core_done) begin
                done_seen = 1;
                got = sb_q.pop_front();
                chk({tag, ".lat"}, cyc, got.lat);
                chk({tag, ".err"}, core_err, got.err);
                chk({tag, ".ir"}, ir, got.ir);
                chk({tag, ".ld"}, load_data, got.ld);
                core_req = 1'b0;
            end
            bus.ready = (rdy_wait == 0) || (vcnt > rdy_wait);
            pv = bus.valid;
            pr = bus.ready;
        end
        n_valid = vcnt;
        chk({tag, ".done_seen"}, done_seen, 1'b1);
        if (!done_seen) begin
            core_req = 1'b0;
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end
        bus.ready = 1'b0; bus.rvalid = 1'b0;
        @(negedge clk);
        chk({tag, ".one_pulse"}, core_done, 1'b0);
        chk({tag, ".err_clr"}, core_err, 1'b0);
        chk({tag, ".valid_idle"}, bus.valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset = 1'b1; core_req = 1'b0; instruction_or_data = 1'b0; mem_write = 1'b0;
        funct3 = 3'b010; pc = '0; alu_result = '0; store_data = '0;
        bus.ready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst.ir", ir, 32'h0000_0013);
        chk("rst.ld", load_data, 32'h0);
        chk("rst.valid", bus.valid, 1'b0);
        chk("rst.we", bus.we, 1'b0);
        chk("rst.done", core_done, 1'b0);
        chk("rst.err", core_err, 1'b0);
        chk("rst.addr", bus.addr, 32'h0);
        chk("rst.wdata", bus.wdata, 32'h0);
        chk("rst.wstrb", bus.wstrb, 4'h0);
        reset = 1'b0;
        @(negedge clk);
        cur_ir = 32'h0000_0013; cur_ld = 32'h0;

        // Fetch, zero-wait bus.
        cur_ir = 32'h0050_0093;
        access("fetch", 1'b0, 1'b0, 3'b000, 32'h100, 32'h0, 32'h0050_0093, 0, 1, 4, 1'b0, cur_ir, cur_ld);
        chk("fetch.addr", cap_addr, 32'h100);
        chk("fetch.we", cap_we, 1'b0);
        chk("fetch.accepts", n_accept, 1);

        // Loads: sign/zero extension on every lane pattern.
        cur_ld = 32'hFFFF_FF80;
        access("lb", 1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF_1234, 0, 1, 4, 1'b0, cur_ir, cur_ld);
        chk("lb.addr", cap_addr, 32'h200);
        cur_ld = 32'h0000_0080;
        access("lbu", 1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF_1234, 0, 1, 4, 1'b0, cur_ir, cur_ld);
        cur_ld = 32'hFFFF_80FF;
        access("lh", 1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 32'h80FF_1234, 0, 1, 4, 1'b0, cur_ir, cur_ld);
        cur_ld = 32'h0000_1234;
        access("lhu", 1'b1, 1'b0, 3'b101, 32'h200, 32'h0, 32'h80FF_1234, 0, 1, 4, 1'b0, cur_ir, cur_ld);
        cur_ld = 32'hDEAD_BEEF;
        access("lw", 1'b1, 1'b0, 3'b010, 32'h204, 32'h0, 32'hDEAD_BEEF, 0, 1, 4, 1'b0, cur_ir, cur_ld);
        chk("lw.addr", cap_addr, 32'h204);

        // Stores: lane replication and strobes, load_data untouched.
        access("sh", 1'b1, 1'b1, 3'b001, 32'h102, 32'h0000_BEEF, 32'h0, 0, 1, 3, 1'b0, cur_ir, cur_ld);
        chk("sh.addr", cap_addr, 32'h100);
        chk("sh.wdata", cap_wdata, 32'hBEEF_BEEF);
        chk("sh.wstrb", cap_wstrb, 4'b1100);
        chk("sh.we", cap_we, 1'b1);
        access("sb", 1'b1, 1'b1, 3'b000, 32'h301, 32'h1234_56A5, 32'h0, 0, 1, 3, 1'b0, cur_ir, cur_ld);
        chk("sb.wdata", cap_wdata, 32'hA5A5_A5A5);
        chk("sb.wstrb", cap_wstrb, 4'b0010);
        chk("sb.addr", cap_addr, 32'h300);

        // Backpressure: ready low for five valid cycles.
        access("bp", 1'b1, 1'b1, 3'b010, 32'h400, 32'hCAFE_F00D, 32'h0, 5, 1, 8, 1'b0, cur_ir, cur_ld);
        chk("bp.valid_cycles", n_valid, 6);
        chk("bp.accepts", n_accept, 1);
        chk("bp.unstable", n_unstable, 0);
        chk("bp.wdata", cap_wdata, 32'hCAFE_F00D);
        chk("bp.wstrb", cap_wstrb, 4'b1111);

        // Misaligned and illegal-size requests never touch the bus.
        access("lw_mis", 1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 1, 1, 1'b1, cur_ir, cur_ld);
        chk("lw_mis.valid_cycles", n_valid, 0);
        access("fetch_mis", 1'b0, 1'b0, 3'b000, 32'h102, 32'h0, 32'h0, 0, 1, 1, 1'b1, cur_ir, cur_ld);
        chk("fetch_mis.valid_cycles", n_valid, 0);
        access("lh_mis", 1'b1, 1'b0, 3'b001, 32'h203, 32'h0, 32'h0, 0, 1, 1, 1'b1, cur_ir, cur_ld);
        access("ld_bad_f3", 1'b1, 1'b0, 3'b011, 32'h200, 32'h0, 32'h0, 0, 1, 1, 1'b1, cur_ir, cur_ld);
        access("st_bad_f3", 1'b1, 1'b1, 3'b100, 32'h200, 32'h55, 32'h0, 0, 1, 1, 1'b1, cur_ir, cur_ld);
        chk("st_bad_f3.valid_cycles", n_valid, 0);

        // Timeouts: no read data, then a request that is never accepted.
        access("tmo_resp", 1'b0, 1'b0, 3'b000, 32'h200, 32'h0, 32'hFFFF_FFFF, 0, 0, TMO + 1, 1'b1, cur_ir, cur_ld);
        chk("tmo_resp.accepts", n_accept, 1);
        access("tmo_req", 1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 100, 1, TMO + 1, 1'b1, cur_ir, cur_ld);
        chk("tmo_req.accepts", n_accept, 0);
        chk("tmo_req.valid_cycles", n_valid, TMO - 1);

        // Stray handshake signals while idle.
        bus.rvalid = 1'b1; bus.ready = 1'b1; bus.rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        bus.rvalid = 1'b0; bus.ready = 1'b0;
        @(negedge clk);
        chk("late_rv.ir", ir, cur_ir);
        chk("late_rv.ld", load_data, cur_ld);
        chk("late_rv.done", core_done, 1'b0);
        chk("late_rv.valid", bus.valid, 1'b0);

        // Reset while the request is on the bus: valid must fall without a clock edge.
        core_req = 1'b1; instruction_or_data = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
        alu_result = 32'h500;
        k = 0;
        while (!bus.valid && k < 6) begin @(negedge clk); k++; end
        chk("rst_req.valid_up", bus.valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("rst_req.valid", bus.valid, 1'b0);
        chk("rst_req.ir", ir, 32'h0000_0013);
        core_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset in RESP after a fetch has loaded the IR.
        cur_ir = 32'h0050_0093; cur_ld = 32'h0;
        access("fetch2", 1'b0, 1'b0, 3'b000, 32'h100, 32'h0, 32'h0050_0093, 0, 1, 4, 1'b0, cur_ir, cur_ld);
        core_req = 1'b1; instruction_or_data = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
        alu_result = 32'h600; bus.ready = 1'b1;
        k = 0;
        while (!bus.valid && k < 6) begin @(negedge clk); k++; end
        chk("rst_resp.valid_up", bus.valid, 1'b1);
        @(negedge clk);
        chk("rst_resp.in_resp", bus.valid, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("rst_resp.valid", bus.valid, 1'b0);
        chk("rst_resp.ir", ir, 32'h0000_0013);
        chk("rst_resp.ld", load_data, 32'h0);
        chk("rst_resp.done", core_done, 1'b0);
        core_req = 1'b0; bus.ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Port is back in IDLE and serves a fresh request with the nominal latency.
        cur_ir = 32'h0000_0013; cur_ld = 32'h0000_00FF;
        access("after_rst", 1'b1, 1'b0, 3'b100, 32'h001, 32'h0, 32'h0000_FF00, 0, 1, 4, 1'b0, cur_ir, cur_ld);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/mc_mem_port.md
Name: mc_mem_port

Overview:
- Unified memory port between the multicycle RISC-V core and a single instruction/data bus.
- Takes one request per FSM memory state (FETCH, MEM_RD, MEM_WR) and selects the address: PC for fetch, ALU result for data.
- Runs a valid/ready bus handshake and stalls the control FSM until the access completes.
- Holds the instruction register (IR) and the load-data register, with size and sign handling per funct3.

Parameters:
- XLEN, 32, data/address width.
- TIMEOUT, 255, maximum cycles spent in REQ+RESP before the access is aborted with an error.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- core_req  in  1  control FSM requests an access this cycle
- instruction_or_data  in  1  0 = fetch (address = pc), 1 = data (address = alu_result)
- mem_write  in  1  1 = store (data accesses only; ignored for fetch)
- funct3  in  3  load/store size code (forced to 3'b010 for fetch)
- pc  in  XLEN  fetch address
- alu_result  in  XLEN  data address
- store_data  in  XLEN  rs2 value, right-aligned
- core_done  out  1  one-cycle completion pulse
- core_stall  out  1  core_req && !core_done
- core_err  out  1  valid with core_done: misaligned access or timeout
- ir  out  32  instruction register
- load_data  out  XLEN  extended load result register
- bus_valid  out  1  request valid
- bus_ready  in  1  request accepted
- bus_we  out  1  write enable
- bus_addr  out  XLEN  word-aligned address (low 2 bits zero)
- bus_wdata  out  XLEN  replicated store data
- bus_wstrb  out  4  byte strobes
- bus_rdata  in  XLEN  read data
- bus_rvalid  in  1  read data valid

Behaviour:
- Reset is asynchronous and active-high. Values held in reset:
  - state = IDLE
  - bus_valid, bus_we, core_done, core_err = 0
  - bus_addr, bus_wdata, bus_wstrb = 0
  - ir = 32'h00000013 (NOP)
  - load_data = 0
  - timeout counter = 0
- States are IDLE, REQ, RESP, DONE.
- IDLE:
  - core_req is sampled here. The effective address, direction, size and byte offset are latched.
  - A misaligned access (half-word with addr[0]=1, word with addr[1:0]≠0, any fetch with addr[1:0]≠0) goes to DONE with core_err=1. No bus activity occurs.
  - Otherwise the next state is REQ.
- REQ:
  - bus_valid=1. bus_addr, bus_we, bus_wdata and bus_wstrb stay stable until bus_ready.
  - On bus_ready, a store goes to DONE and a load/fetch goes to RESP. bus_valid drops the cycle after acceptance.
- RESP:
  - bus_rvalid is valid from the cycle after acceptance onward.
  - On bus_rvalid, a fetch sets ir <= bus_rdata. A load sets load_data <= extract(bus_rdata, offset, funct3). The next state is DONE.
- DONE:
  - core_done=1 for exactly one cycle, then IDLE.
  - core_err is held alongside core_done and cleared on return to IDLE.
- Latency from core_req in IDLE to core_done, with zero bus wait:
  - store: 3 cycles
  - load/fetch: 4 cycles
  - misaligned: 1 cycle
- Load extract:
  - byte = rdata[8*off +: 8]; half = rdata[16*off[1] +: 16]
  - funct3 000 = LB, sign-extend byte
  - funct3 001 = LH, sign-extend half
  - funct3 010 = LW, full word
  - funct3 100 = LBU, zero-extend byte
  - funct3 101 = LHU, zero-extend half
  - Any other funct3 sets core_err=1 and leaves load_data unchanged.
- Store:
  - SB: wdata = {4{sd[7:0]}}, wstrb = 0001 << off
  - SH: wdata = {2{sd[15:0]}}, wstrb = 0011 << off
  - SW: wdata = sd, wstrb = 1111
  - Other funct3 values flag an error.
- Timeout:
  - The counter increments each cycle in REQ/RESP and clears in IDLE.
  - When it reaches TIMEOUT: go to DONE with core_err=1, drop bus_valid, leave ir/load_data unchanged.
  - A late bus_rvalid arriving in IDLE is ignored.
- core_req is only sampled in IDLE. Deasserting it mid-access does not abort the access.
- bus_ready/bus_rvalid arriving outside REQ/RESP are ignored.
- core_stall is combinational: high while the core requests and no completion pulse is present.
- Reset mid-access returns to IDLE immediately. bus_valid falls asynchronously, and ir/load_data reload their reset values.

Decomposition:
- Shared package holds:
  - funct3 size constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - port state enum (IDLE/REQ/RESP/DONE)
  - the NOP constant
  - these are shared with the control FSM and decoder
- One natural sub-module, mc_lsu_align (combinational):
  - store alignment (wdata/wstrb)
  - load extraction
  - misalignment/illegal-size detection
- The FSM, timeout counter and IR/load_data registers stay in mc_mem_port.

Test Plan:
- Fetch, zero-wait bus (bus_ready tied high, rvalid 1 cycle later):
  - pc=0x100, rdata=0x00500093 -> bus_addr=0x100, bus_we=0
  - ir=0x00500093, core_done 4 cycles after core_req, stall high for cycles 1-3
- LB at 0x203, rdata=0x80FF1234 -> wstrb unused, load_data=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH at 0x102, store_data=0x0000BEEF:
  - bus_wdata=0xBEEFBEEF, wstrb=1100, bus_addr=0x100
  - core_done after 3 cycles, load_data unchanged
- Backpressure: bus_ready low for 5 cycles -> bus_valid/addr/wdata stable all 5 cycles, single acceptance, single core_done.
- LW at 0x101 -> core_err=1 with core_done 1 cycle after core_req, bus_valid never asserts.
- Timeout and reset:
  - With TIMEOUT=8 and rvalid never asserting -> core_err at the 8th REQ/RESP cycle, ir unchanged.
  - Separately, reset asserted in RESP -> bus_valid=0 immediately, ir=0x00000013, state IDLE.
